// File: rtl/micro_seq_pkg.sv
// Shared encodings for the micro-sequencer next-address mode field.
// Control ROM generators import this so ROM words and the sequencer agree.
package micro_seq_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD    = 3'b000,
    MODE_INC     = 3'b001,
    MODE_JUMP    = 3'b010,
    MODE_BRANCH  = 3'b011,
    MODE_CALL    = 3'b100,
    MODE_RET     = 3'b101,
    MODE_LOAD    = 3'b110,
    MODE_RESTART = 3'b111
  } mode_e;

endpackage

// File: rtl/micro_stack.sv
// LIFO of return addresses for the micro-sequencer.
// Updates on the falling clock edge, alongside the uPC register.
module micro_stack #(
  parameter  int AW          = 4,
  parameter  int STACK_DEPTH = 2,
  localparam int CW          = $clog2(STACK_DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_clear,
  input  logic [AW-1:0] i_data,
  output logic [AW-1:0] o_top,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  logic [AW-1:0] r_mem [STACK_DEPTH];
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_empty;
  logic          w_do_push;
  logic [AW-1:0] w_top;

  assign w_full    = (r_count == CW'(STACK_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_push = i_push && !w_full && !i_rst && !i_clear;

  always_ff @(negedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (i_push && !w_full) begin
      r_count <= r_count + CW'(1);
    end else if (i_pop && !w_empty) begin
      r_count <= r_count - CW'(1);
    end
  end

  // Entry contents are don't-care after reset, so storage has no reset.
  always_ff @(negedge i_clk) begin
    if (w_do_push) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (CW'(i) == r_count) r_mem[i] <= i_data;
      end
    end
  end

  always_comb begin
    w_top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (CW'(i + 1) == r_count) w_top = r_mem[i];
    end
  end

  assign o_top   = w_top;
  assign o_count = r_count;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/micro_sequencer.sv
// Micro-program counter with mode-driven next-address logic and return stack.
// All state advances on the falling edge so the ROM sees a stable address at the rising edge.
module micro_sequencer
  import micro_seq_pkg::*;
#(
  parameter  int AW          = 4,
  parameter  int STACK_DEPTH = 2,
  parameter  int NCOND       = 4,
  localparam int SW          = (NCOND > 1) ? $clog2(NCOND) : 1,
  localparam int CW          = $clog2(STACK_DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic [MODE_W-1:0] MODE,
  input  logic [AW-1:0]     JMP_ADDR,
  input  logic [AW-1:0]     IN_ADDR,
  input  logic [NCOND-1:0]  COND,
  input  logic [SW-1:0]     COND_SEL,
  input  logic              COND_POL,
  output logic [AW-1:0]     UPC_ADDR,
  output logic [CW-1:0]     SP,
  output logic              STACK_OVF,
  output logic              STACK_UNF
);

  logic [AW-1:0] r_upc;
  logic          r_ovf;
  logic          r_unf;

  logic [AW-1:0] w_inc;
  logic [AW-1:0] w_next;
  logic [AW-1:0] w_top;
  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_sel_bit;
  logic          w_taken;
  logic          w_push;
  logic          w_pop;
  logic          w_clear;
  logic          w_set_ovf;
  logic          w_set_unf;

  // Out-of-range selects read as 0, so the branch outcome collapses to COND_POL.
  always_comb begin
    w_sel_bit = 1'b0;
    for (int i = 0; i < NCOND; i++) begin
      if (SW'(i) == COND_SEL) w_sel_bit = COND[i];
    end
  end

  assign w_inc   = r_upc + AW'(1);
  assign w_taken = w_sel_bit ^ COND_POL;

  always_comb begin
    w_next    = r_upc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_clear   = 1'b0;
    w_set_ovf = 1'b0;
    w_set_unf = 1'b0;
    if (EN) begin
      case (mode_e'(MODE))
        MODE_HOLD:    w_next = r_upc;
        MODE_INC:     w_next = w_inc;
        MODE_JUMP:    w_next = JMP_ADDR;
        MODE_BRANCH:  w_next = w_taken ? JMP_ADDR : w_inc;
        MODE_CALL: begin
          if (!w_full) begin
            w_push = 1'b1;
            w_next = JMP_ADDR;
          end else begin
            w_set_ovf = 1'b1;
          end
        end
        MODE_RET: begin
          if (!w_empty) begin
            w_pop  = 1'b1;
            w_next = w_top;
          end else begin
            w_next    = '0;
            w_set_unf = 1'b1;
          end
        end
        MODE_LOAD:    w_next = IN_ADDR;
        MODE_RESTART: begin
          w_next  = '0;
          w_clear = 1'b1;
        end
        default:      w_next = r_upc;
      endcase
    end
  end

  always_ff @(negedge CLK) begin
    if (RST) begin
      r_upc <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_upc <= w_next;
      if (w_set_ovf) r_ovf <= 1'b1;
      if (w_set_unf) r_unf <= 1'b1;
    end
  end

  micro_stack #(
    .AW          (AW),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (w_clear),
    .i_data  (w_inc),
    .o_top   (w_top),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign UPC_ADDR  = r_upc;
  assign SP        = w_count;
  assign STACK_OVF = r_ovf;
  assign STACK_UNF = r_unf;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed and randomized checks of micro_sequencer against a queue-based reference model.
module tb_micro_sequencer;
  import micro_seq_pkg::*;

  localparam int AW    = 4;
  localparam int DEPTH = 2;
  localparam int NCOND = 4;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         EN = 1'b0;
  logic [2:0]   MODE = 3'b000;
  logic [AW-1:0] JMP_ADDR = '0;
  logic [AW-1:0] IN_ADDR = '0;
  logic [NCOND-1:0] COND = '0;
  logic [1:0]   COND_SEL = '0;
  logic         COND_POL = 1'b0;
  logic [AW-1:0] UPC_ADDR;
  logic [1:0]   SP;
  logic         STACK_OVF;
  logic         STACK_UNF;

  int n_assert = 0;
  int n_fail   = 0;

  int m_upc = 0;
  int m_stk[$];
  int m_ovf = 0;
  int m_unf = 0;

  always #5 CLK = ~CLK;

  micro_sequencer #(.AW(AW), .STACK_DEPTH(DEPTH), .NCOND(NCOND)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE), .JMP_ADDR(JMP_ADDR),
    .IN_ADDR(IN_ADDR), .COND(COND), .COND_SEL(COND_SEL), .COND_POL(COND_POL),
    .UPC_ADDR(UPC_ADDR), .SP(SP), .STACK_OVF(STACK_OVF), .STACK_UNF(STACK_UNF)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: addresses are plain integers modulo 2**AW, stack is a queue.
  task automatic model(input int rst, input int en, input int mode, input int jmp,
                       input int inaddr, input int cond, input int sel, input int pol);
    int inc;
    int bitv;
    if (rst != 0) begin
      m_upc = 0; m_stk.delete(); m_ovf = 0; m_unf = 0;
    end else if (en != 0) begin
      inc = (m_upc + 1) % (1 << AW);
      case (mode)
        1: m_upc = inc;
        2: m_upc = jmp;
        3: begin
          bitv = (sel < NCOND) ? ((cond >> sel) & 1) : 0;
          m_upc = ((bitv ^ pol) != 0) ? jmp : inc;
        end
        4: if (m_stk.size() < DEPTH) begin m_stk.push_back(inc); m_upc = jmp; end
           else m_ovf = 1;
        5: if (m_stk.size() > 0) m_upc = m_stk.pop_back();
           else begin m_upc = 0; m_unf = 1; end
        6: m_upc = inaddr;
        7: begin m_upc = 0; m_stk.delete(); end
        default: ;
      endcase
    end
  endtask

  task automatic step(input string tag, input int rst, input int en, input int mode,
                      input int jmp, input int inaddr, input int cond, input int sel, input int pol);
    RST = rst[0]; EN = en[0]; MODE = mode[2:0]; JMP_ADDR = jmp[AW-1:0];
    IN_ADDR = inaddr[AW-1:0]; COND = cond[NCOND-1:0]; COND_SEL = sel[1:0]; COND_POL = pol[0];
    @(negedge CLK);
    model(rst, en, mode, jmp, inaddr, cond, sel, pol);
    @(posedge CLK);
    #1;
    chk({tag, ".upc"}, int'(UPC_ADDR), m_upc);
    chk({tag, ".sp"},  int'(SP), m_stk.size());
    chk({tag, ".ovf"}, int'(STACK_OVF), m_ovf);
    chk({tag, ".unf"}, int'(STACK_UNF), m_unf);
  endtask

  initial begin
    // reset and hold
    step("rst0", 1, 1, 1, 0, 0, 0, 0, 0);
    step("rst1", 1, 1, 1, 0, 0, 0, 0, 0);
    chk("rst_upc", int'(UPC_ADDR), 0);
    for (int i = 0; i < 3; i++) step("hold_en0", 0, 0, 1, 0, 0, 0, 0, 0);
    chk("hold_upc", int'(UPC_ADDR), 0);

    // increment wrap
    for (int i = 1; i <= 16; i++) begin
      step("inc", 0, 1, 1, 0, 0, 0, 0, 0);
      chk("inc_const", int'(UPC_ADDR), i % 16);
    end

    // branch polarity
    step("ld3", 0, 1, 6, 0, 3, 0, 0, 0);
    step("br_t", 0, 1, 3, 9, 0, 4'b0100, 2, 0);
    chk("br_taken", int'(UPC_ADDR), 9);
    step("ld3", 0, 1, 6, 0, 3, 0, 0, 0);
    step("br_pol", 0, 1, 3, 9, 0, 4'b0100, 2, 1);
    chk("br_pol_nt", int'(UPC_ADDR), 4);
    step("ld3", 0, 1, 6, 0, 3, 0, 0, 0);
    step("br_nt", 0, 1, 3, 9, 0, 4'b0000, 2, 0);
    chk("br_not_taken", int'(UPC_ADDR), 4);

    // call/return nesting
    step("ld2", 0, 1, 6, 0, 2, 0, 0, 0);
    step("call8", 0, 1, 4, 8, 0, 0, 0, 0);
    chk("call8_upc", int'(UPC_ADDR), 8);
    step("call12", 0, 1, 4, 12, 0, 0, 0, 0);
    chk("call12_sp", int'(SP), 2);
    step("ret1", 0, 1, 5, 0, 0, 0, 0, 0);
    chk("ret1_upc", int'(UPC_ADDR), 9);
    step("ret2", 0, 1, 5, 0, 0, 0, 0, 0);
    chk("ret2_upc", int'(UPC_ADDR), 3);

    // overflow / underflow
    step("callA", 0, 1, 4, 1, 0, 0, 0, 0);
    step("callB", 0, 1, 4, 7, 0, 0, 0, 0);
    step("call_ovf", 0, 1, 4, 5, 0, 0, 0, 0);
    chk("ovf_upc", int'(UPC_ADDR), 7);
    chk("ovf_flag", int'(STACK_OVF), 1);
    step("drain1", 0, 1, 5, 0, 0, 0, 0, 0);
    step("drain2", 0, 1, 5, 0, 0, 0, 0, 0);
    step("ret_unf", 0, 1, 5, 0, 0, 0, 0, 0);
    chk("unf_flag", int'(STACK_UNF), 1);
    step("restart", 0, 1, 7, 0, 0, 0, 0, 0);
    chk("restart_flags", int'({STACK_OVF, STACK_UNF}), 3);
    step("rst_flags", 1, 1, 0, 0, 0, 0, 0, 0);
    chk("rst_flags_clr", int'({STACK_OVF, STACK_UNF}), 0);

    // load, call at all-ones, reset mid-call
    step("ldA", 0, 1, 6, 0, 10, 0, 0, 0);
    chk("load_upc", int'(UPC_ADDR), 10);
    step("ld15", 0, 1, 6, 0, 15, 0, 0, 0);
    step("call_wrap", 0, 1, 4, 6, 0, 0, 0, 0);
    step("ret_wrap", 0, 1, 5, 0, 0, 0, 0, 0);
    chk("call_wrap_ret", int'(UPC_ADDR), 0);
    step("ld5", 0, 1, 6, 0, 5, 0, 0, 0);
    step("rst_call", 1, 1, 4, 9, 0, 0, 0, 0);
    chk("rst_call_sp", int'(SP), 0);
    step("ret_after_rst", 0, 1, 5, 0, 0, 0, 0, 0);
    chk("no_push_unf", int'(STACK_UNF), 1);

    // randomized
    for (int i = 0; i < 500; i++) begin
      step("rand",
           ($urandom_range(0, 39) == 0) ? 1 : 0,
           ($urandom_range(0, 7) != 0) ? 1 : 0,
           int'($urandom_range(0, 7)),
           int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)),
           int'($urandom_range(0, 3)),
           int'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Parametrised successor to the present-state sequencer.
- Holds the micro-program counter (uPC) that addresses the control ROM.
- Computes the next uPC from a mode field supplied by the control ROM word: hold, increment, jump, conditional branch, call/return through a hardware return stack, external load, and restart.
- Sits between the control ROM output fields and the control ROM address input of the multiplier controller, and of future multi-cycle units.

Parameters:
- AW, 4, uPC/address width in bits (ROM depth = 2**AW).
- STACK_DEPTH, 2, number of return-address entries (>=1).
- NCOND, 4, number of status/condition inputs selectable for branches (>=1).

Ports:
- CLK  in  1  system clock; all state updates on falling edge, ROM/datapath sample on rising edge.
- RST  in  1  synchronous reset, active-high, sampled on falling edge of CLK.
- EN  in  1  advance enable; low = freeze all state.
- MODE  in  3  next-address mode from control ROM.
- JMP_ADDR  in  AW  target for JUMP/BRANCH/CALL.
- IN_ADDR  in  AW  externally computed next state (LOAD mode).
- COND  in  NCOND  status flags from datapath (e.g. counter zero, multiplier bit).
- COND_SEL  in  max(1,$clog2(NCOND))  selects COND bit.
- COND_POL  in  1  0 = branch if selected bit is 1, 1 = branch if bit is 0.
- UPC_ADDR  out  AW  present state, fed to control ROM.
- SP  out  $clog2(STACK_DEPTH+1)  stack occupancy.
- STACK_OVF  out  1  sticky: CALL attempted with stack full.
- STACK_UNF  out  1  sticky: RET attempted with stack empty.

Behaviour:
- Reset
  - RST=1 at a falling edge: UPC_ADDR=0, SP=0, STACK_OVF=0, STACK_UNF=0. Stack contents are don't-care.
  - RST has priority over EN and MODE. Reset mid-CALL/RET discards the operation.
- Enable
  - EN=0 (RST=0): all registers hold.
- Latency
  - Registered outputs only. Each update is applied at the falling edge, one update per falling edge, and is visible to the ROM half a cycle later.
- Modes, with EN=1 and inc = UPC_ADDR+1 mod 2**AW:
  - 000 HOLD: uPC unchanged.
  - 001 INC: uPC <= inc. Wraps from all-ones to 0; no flag.
  - 010 JUMP: uPC <= JMP_ADDR.
  - 011 BRANCH: taken = COND[COND_SEL] XOR COND_POL. uPC <= taken ? JMP_ADDR : inc. COND_SEL >= NCOND gives taken = COND_POL.
  - 100 CALL
    - Stack not full: push inc, SP+1, uPC <= JMP_ADDR.
    - Stack full (SP==STACK_DEPTH): no push, uPC holds, STACK_OVF <= 1.
  - 101 RET
    - Stack not empty: uPC <= top entry, SP-1.
    - Stack empty: uPC <= 0, STACK_UNF <= 1.
  - 110 LOAD: uPC <= IN_ADDR. This is the legacy direct next-state behaviour.
  - 111 RESTART: uPC <= 0, SP <= 0, sticky flags unchanged.
- Flags
  - STACK_OVF and STACK_UNF clear only on RST.
- Stack
  - LIFO, entries AW wide.
  - Push and pop never occur in the same edge, because the modes are mutually exclusive.
  - A CALL at address all-ones pushes 0.
- Inputs
  - All inputs are sampled only at the falling edge. No combinational path from inputs to outputs.

Decomposition:
- Shared package micro_seq_pkg holds:
  - Mode encodings: MODE_HOLD, MODE_INC, MODE_JUMP, MODE_BRANCH, MODE_CALL, MODE_RET, MODE_LOAD, MODE_RESTART.
  - Mode field width constant (3), so the control ROM generators use the same constants.
- One sub-module, micro_stack:
  - Parametrised by AW and STACK_DEPTH.
  - push/pop/clear inputs; top, count, full, empty outputs.
  - Same clock edge and synchronous reset.
- The top level holds the uPC register, next-address mux, condition select and sticky flags.

Test Plan:
- Reset and hold: RST=1 for 2 edges with MODE=INC → UPC_ADDR=0, SP=0, flags 0. Then EN=0 with MODE=INC for 3 edges → UPC_ADDR stays 0.
- Increment wrap (AW=4): INC from 0 for 16 edges → UPC_ADDR 1..15, then 0, no flags.
- Branch polarity: uPC=3, COND=4'b0100, COND_SEL=2.
  - COND_POL=0, JMP_ADDR=9 → uPC=9.
  - Repeat from uPC=3 with COND_POL=1 → uPC=4.
  - COND_SEL=2 with COND[2]=0 and COND_POL=0 → uPC=4.
- Call/return nesting (STACK_DEPTH=2):
  - At uPC=2, CALL 8 → uPC=8, SP=1.
  - At 8, CALL 12 → uPC=12, SP=2.
  - RET → uPC=9, SP=1. RET → uPC=3, SP=0.
- Overflow/underflow:
  - SP=2, CALL 5 at uPC=7 → uPC stays 7, SP=2, STACK_OVF=1.
  - Drain the stack, then RET at SP=0 → uPC=0, STACK_UNF=1.
  - RESTART keeps both flags set; RST clears both.
- LOAD and reset mid-operation:
  - LOAD IN_ADDR=4'hA → uPC=A.
  - CALL issued with RST=1 on the same edge → uPC=0, SP=0, nothing pushed.
